// File: rtl/ysyx22041405_pkg.sv
// Shared types and constants for the ysyx22041405 instruction fetch unit.
// The FAULT state exists only when YSYX22041405_IFU_MISALIGN_EN is defined.
package ysyx22041405_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;

   typedef enum logic [2:0] {
      IFU_IDLE  = 3'd0,
      IFU_REQ   = 3'd1,
      IFU_WAIT  = 3'd2,
      IFU_HOLD  = 3'd3,
      IFU_DROP  = 3'd4
`ifdef YSYX22041405_IFU_MISALIGN_EN
      ,
      IFU_FAULT = 3'd5
`endif
   } ifu_state_e;

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/ysyx22041405_ifu_if.sv
// Bundle of the IFU memory fetch port, decoder handshake and execute redirect.
// id_misalign is present only when YSYX22041405_IFU_MISALIGN_EN is defined.
interface ysyx22041405_ifu_if #(
   parameter int WIDTH = 32
);
   logic             ifu_req_valid;
   logic             ifu_req_ready;
   logic [WIDTH-1:0] ifu_req_addr;
   logic             ifu_resp_valid;
   logic [WIDTH-1:0] ifu_resp_data;
   logic             id_valid;
   logic             id_ready;
   logic [WIDTH-1:0] id_pc;
   logic [WIDTH-1:0] id_inst;
   logic             redirect_valid;
   logic [WIDTH-1:0] redirect_pc;
`ifdef YSYX22041405_IFU_MISALIGN_EN
   logic             id_misalign;
`endif

   modport master (
      output ifu_req_valid, ifu_req_addr, id_valid, id_pc, id_inst,
`ifdef YSYX22041405_IFU_MISALIGN_EN
      output id_misalign,
`endif
      input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, id_ready,
      input  redirect_valid, redirect_pc
   );

   modport slave (
      input  ifu_req_valid, ifu_req_addr, id_valid, id_pc, id_inst,
`ifdef YSYX22041405_IFU_MISALIGN_EN
      input  id_misalign,
`endif
      output ifu_req_ready, ifu_resp_valid, ifu_resp_data, id_ready,
      output redirect_valid, redirect_pc
   );

endinterface

// File: rtl/ysyx22041405_pc_reg.sv
// Program counter: reset load, redirect load (highest priority) and +4 advance.
// The +4 adder wraps naturally modulo 2^WIDTH.
module ysyx22041405_pc_reg
   import ysyx22041405_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             redir_i,
   input  logic [WIDTH-1:0] redir_pc_i,
   output logic [WIDTH-1:0] pc_o
);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (redir_i) begin
         pc_d = redir_pc_i;
      end else if (inc_i) begin
         pc_d = pc_q + WIDTH'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/ysyx22041405_ifu.sv
// Instruction fetch unit: one outstanding word fetch, decoder hand-off, redirect squash.
// Optional misaligned-redirect fault reporting with YSYX22041405_IFU_MISALIGN_EN.
module ysyx22041405_ifu
   import ysyx22041405_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  rst,
   ysyx22041405_ifu_if.master    bus
);

   ifu_state_e       state_q;
   logic [WIDTH-1:0] id_pc_q;
   logic [WIDTH-1:0] id_inst_q;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] redir_pc;
   logic             req_hs;
   logic             resp;
   logic             pc_inc;

`ifdef YSYX22041405_IFU_MISALIGN_EN
   logic             mis_q;
   logic             fault_vld_q;
   // a fault entered with a fetch still in flight must swallow that response later
   logic             drain_q;

   assign redir_pc = bus.redirect_pc;
`else
   assign redir_pc = bus.redirect_pc & ~WIDTH'(3);
`endif

   assign req_hs = (state_q == IFU_REQ) && bus.ifu_req_ready;
   assign resp   = bus.ifu_resp_valid;
   assign pc_inc = (state_q == IFU_HOLD) && bus.id_ready && !bus.redirect_valid;

   ysyx22041405_pc_reg #(
      .WIDTH    (WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (pc_inc),
      .redir_i    (bus.redirect_valid),
      .redir_pc_i (redir_pc),
      .pc_o       (pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IFU_IDLE;
         id_pc_q   <= '0;
         id_inst_q <= '0;
`ifdef YSYX22041405_IFU_MISALIGN_EN
         mis_q       <= 1'b0;
         fault_vld_q <= 1'b0;
         drain_q     <= 1'b0;
`endif
      end else begin
`ifdef YSYX22041405_IFU_MISALIGN_EN
         if (resp) begin
            drain_q <= 1'b0;
         end
`endif
         if (bus.redirect_valid) begin
`ifdef YSYX22041405_IFU_MISALIGN_EN
            if (is_misaligned(bus.redirect_pc[1:0])) begin
               state_q     <= IFU_FAULT;
               id_pc_q     <= bus.redirect_pc;
               id_inst_q   <= '0;
               mis_q       <= 1'b1;
               fault_vld_q <= 1'b1;
               if (req_hs || (((state_q == IFU_WAIT) || (state_q == IFU_DROP)) && !resp)) begin
                  drain_q <= 1'b1;
               end
            end else begin
               mis_q       <= 1'b0;
               fault_vld_q <= 1'b0;
`endif
               case (state_q)
                  IFU_REQ:            state_q <= req_hs ? IFU_DROP : IFU_REQ;
                  IFU_WAIT, IFU_DROP: state_q <= resp ? IFU_REQ : IFU_DROP;
`ifdef YSYX22041405_IFU_MISALIGN_EN
                  IFU_FAULT:          state_q <= (drain_q && !resp) ? IFU_DROP : IFU_REQ;
`endif
                  default:            state_q <= IFU_REQ;
               endcase
`ifdef YSYX22041405_IFU_MISALIGN_EN
            end
`endif
         end else begin
            case (state_q)
               IFU_IDLE: state_q <= IFU_REQ;
               IFU_REQ: begin
                  if (req_hs) begin
                     state_q <= IFU_WAIT;
                  end
               end
               IFU_WAIT: begin
                  if (resp) begin
                     id_inst_q <= bus.ifu_resp_data;
                     id_pc_q   <= pc;
                     state_q   <= IFU_HOLD;
                  end
               end
               IFU_HOLD: begin
                  if (bus.id_ready) begin
                     state_q <= IFU_REQ;
                  end
               end
               IFU_DROP: begin
                  if (resp) begin
                     state_q <= IFU_REQ;
                  end
               end
`ifdef YSYX22041405_IFU_MISALIGN_EN
               IFU_FAULT: begin
                  if (bus.id_ready) begin
                     fault_vld_q <= 1'b0;
                  end
               end
`endif
               default: state_q <= IFU_IDLE;
            endcase
         end
      end
   end

   assign bus.ifu_req_valid = (state_q == IFU_REQ);
   assign bus.ifu_req_addr  = pc;
   assign bus.id_pc         = id_pc_q;
   assign bus.id_inst       = id_inst_q;
`ifdef YSYX22041405_IFU_MISALIGN_EN
   assign bus.id_valid      = (state_q == IFU_HOLD) || ((state_q == IFU_FAULT) && fault_vld_q);
   assign bus.id_misalign   = mis_q;
`else
   assign bus.id_valid      = (state_q == IFU_HOLD);
`endif

endmodule
